// File: rtl/uart_tx_block_scheduler.sv
// uart_tx_block_scheduler: round-robin arbiter that latches one requester's block
// and feeds it MSB-byte-first through the UART_TX start/busy handshake.
module uart_tx_block_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int BLOCK_BYTES   = 16,
    parameter int START_TIMEOUT = 1024,
    localparam int LW           = $clog2(BLOCK_BYTES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*8*BLOCK_BYTES-1:0] req_block,
    input  logic [NUM_REQ*LW-1:0]           req_len,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    output logic                            sched_busy,
    output logic [7:0]                      tx_data,
    output logic                            tx_start,
    input  logic                            tx_busy
);
    localparam int W  = 8 * BLOCK_BYTES;
    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t          state;
    logic [W-1:0]    data_buf;
    logic [LW-1:0]   len, byte_cnt, len_in, len_clamped;
    logic [GW-1:0]   rr, g, gnt;
    logic [TW-1:0]   tcnt;
    logic            hit;
    int              j;

    // Scan downward so the smallest offset from rr is the last (winning) assignment.
    always_comb begin
        gnt = '0;
        hit = 1'b0;
        j   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_valid[j]) begin
                gnt = GW'(j);
                hit = 1'b1;
            end
        end
    end

    assign len_in      = req_len[gnt*LW +: LW];
    assign len_clamped = (len_in > LW'(BLOCK_BYTES)) ? LW'(BLOCK_BYTES) : len_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            req_ack    <= '0;
            req_done   <= '0;
            req_err    <= '0;
            sched_busy <= 1'b0;
            rr         <= '0;
        end else begin
            tx_start <= 1'b0;
            req_ack  <= '0;
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: if (hit) begin
                    data_buf     <= req_block[gnt*W +: W];
                    len          <= len_clamped;
                    byte_cnt     <= '0;
                    g            <= gnt;
                    req_ack[gnt] <= 1'b1;
                    rr           <= (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
                    sched_busy   <= 1'b1;
                    state        <= LOAD;
                end
                // A zero-length block completes here without ever touching the UART.
                LOAD: if (len == '0) begin
                    req_done[g] <= 1'b1;
                    sched_busy  <= 1'b0;
                    state       <= IDLE;
                end else begin
                    tx_data  <= data_buf[W-1 -: 8];
                    tx_start <= 1'b1;
                    tcnt     <= '0;
                    state    <= SEND;
                end
                SEND: if (tx_busy) begin
                    state <= WAIT;
                end else if (tcnt == TW'(START_TIMEOUT - 1)) begin
                    req_err[g] <= 1'b1;
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                WAIT: if (!tx_busy) begin
                    if (byte_cnt == len - 1'b1) begin
                        req_done[g] <= 1'b1;
                        sched_busy  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        data_buf <= data_buf << 8;
                        byte_cnt <= byte_cnt + 1'b1;
                        state    <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_block_scheduler.sv
// tb_uart_tx_block_scheduler: directed + random requests against a transaction-level
// model of the arbitration order and the expected byte stream per block.
module tb_uart_tx_block_scheduler;
    localparam int N  = 2;
    localparam int BB = 16;
    localparam int TO = 16;
    localparam int W  = 8 * BB;
    localparam int LW = $clog2(BB + 1);

    logic              clk = 1'b0, rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*W-1:0]    req_block = '0;
    logic [N*LW-1:0]   req_len   = '0;
    logic [N-1:0]      req_ack, req_done, req_err;
    logic              sched_busy, tx_start, tx_busy;
    logic [7:0]        tx_data;

    always #5 clk = ~clk;

    uart_tx_block_scheduler #(.NUM_REQ(N), .BLOCK_BYTES(BB), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_block(req_block), .req_len(req_len),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .sched_busy(sched_busy),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART model: captures each started byte, stays busy for a few cycles
    int         busy_cnt = 0;
    int         busy_len = 10;
    bit         never_busy = 0, rnd_busy = 0;
    logic [7:0] obs[$];

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            obs.delete();
        end else begin
            if (tx_start) obs.push_back(tx_data);
            if (tx_start && !never_busy) busy_cnt <= rnd_busy ? int'($urandom_range(1, 12)) : busy_len;
            else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = busy_cnt != 0;

    // Inputs as they were at each active edge, for the grant model
    bit              snap_rst = 0;
    logic [N-1:0]    snap_valid;
    logic [N*W-1:0]  snap_block;
    logic [N*LW-1:0] snap_len;
    int              cyc = 0;

    always @(posedge clk) begin
        snap_rst   <= rst;
        snap_valid <= req_valid;
        snap_block <= req_block;
        snap_len   <= req_len;
        cyc        <= cyc + 1;
    end

    function automatic int pick(input logic [N-1:0] v, input int r);
        for (int i = 0; i < N; i++) if (v[(r + i) % N]) return (r + i) % N;
        return -1;
    endfunction

    int           m_rr = 0, base = 0, start_cyc = 0, n_end = 0, g, l;
    bit           exp_start = 0;
    logic [N-1:0] cur_mask = '0;
    logic [W-1:0] blk;
    logic [7:0]   exp_q[$];
    int           glog[$];

    always @(negedge clk) begin
        if (snap_rst) begin
            chk("reset_outputs", {req_ack, req_done, req_err, sched_busy, tx_start, tx_data}, 0);
            m_rr = 0; cur_mask = '0; exp_start = 0; base = 0;
        end else begin
            if (|{req_ack, req_done, req_err}) chk("one_pulse", $countones({req_ack, req_done, req_err}), 1);
            if (exp_start) begin
                exp_start = 0;
                chk("start_latency", tx_start, exp_q.size() != 0);
            end
            if (tx_start) start_cyc = cyc;
            if (|req_ack) begin
                g = pick(snap_valid, m_rr);
                cur_mask = (g < 0) ? '0 : N'(1) << g;
                chk("grant", req_ack, cur_mask);
                glog.push_back(g);
                exp_q.delete();
                if (g >= 0) begin
                    m_rr = (g + 1) % N;
                    blk  = snap_block[g*W +: W];
                    l    = int'(snap_len[g*LW +: LW]);
                    if (l > BB) l = BB;
                    for (int k = 0; k < l; k++) exp_q.push_back(blk[W-1-8*k -: 8]);
                end
                base = obs.size();
                exp_start = 1;
            end
            if (|req_done) begin
                chk("done_owner", req_done, cur_mask);
                chk("done_bytes", obs.size() - base, exp_q.size());
                for (int k = 0; k < exp_q.size() && base + k < obs.size(); k++)
                    chk("byte", obs[base + k], exp_q[k]);
                cur_mask = '0;
                n_end++;
            end
            if (|req_err) begin
                chk("err_owner", req_err, cur_mask);
                chk("err_expected", never_busy, 1);
                chk("err_latency", cyc - start_cyc, TO);
                chk("err_bytes", obs.size() - base, 1);
                cur_mask = '0;
                n_end++;
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] b, input int len);
        req_block[i*W +: W]   = b;
        req_len[i*LW +: LW]   = LW'(len);
        req_valid[i]          = 1'b1;
    endtask

    task automatic step(input bit hold);
        @(negedge clk);
        #1;
        if (!hold) req_valid &= ~req_ack;
    endtask

    task automatic run(input int ends, input bit hold);
        int t = n_end + ends;
        int budget = 0;
        while (n_end < t && budget < 20000) begin
            step(hold);
            budget++;
        end
        if (n_end < t) chk("wait_budget", n_end, t);
    endtask

    function automatic logic [W-1:0] rand_block();
        logic [W-1:0] b;
        for (int k = 0; k < W / 32; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        int s, e0, budget, b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Both held from reset: strict alternation 0,1,0,1
        s = glog.size();
        set_req(0, rand_block(), 5);
        set_req(1, rand_block(), 4);
        run(4, 1);
        req_valid = '0;
        for (int k = 0; k < 4; k++) chk("alternate", glog[s + k], k % 2);

        // Full 16-byte block 00..0F
        set_req(0, 128'h000102030405060708090A0B0C0D0E0F, 16);
        run(1, 0);
        chk("full_grant", glog[glog.size() - 1], 0);

        // Zero-length on req1 and over-length (clamped) on req0
        set_req(1, rand_block(), 0);
        set_req(0, rand_block(), 20);
        run(2, 0);
        chk("zero_len_first", glog[glog.size() - 2], 1);

        // Start timeout, then normal service
        never_busy = 1;
        set_req(0, rand_block(), 7);
        run(1, 0);
        never_busy = 0;
        repeat (2) step(0);
        set_req(0, rand_block(), 2);
        run(1, 0);

        // Reset during byte 5 of a 16-byte block
        b0 = obs.size();
        e0 = n_end;
        budget = 0;
        set_req(0, rand_block(), 16);
        while (obs.size() < b0 + 5 && budget < 2000) begin
            step(0);
            budget++;
        end
        chk("reach_byte5", obs.size() >= b0 + 5, 1);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        repeat (4) step(0);
        chk("no_end_on_reset", n_end, e0);
        set_req(1, {8'h4F, 8'h4B, 8'h0A, 104'h0}, 3);
        run(1, 0);
        chk("post_reset_grant", glog[glog.size() - 1], 1);

        // Random requests with random UART busy times
        rnd_busy = 1;
        repeat (40) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 1)) set_req(i, rand_block(), $urandom_range(0, 20));
            if (req_valid == '0) set_req($urandom_range(0, N - 1), rand_block(), $urandom_range(0, 20));
            run(1, 0);
        end
        budget = 0;
        while ((req_valid != '0 || sched_busy) && budget < 5000) begin
            step(0);
            budget++;
        end
        chk("drain", {req_valid, sched_busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_block_scheduler.md
Name: uart_tx_block_scheduler

Overview:
Shares the single UART transmitter between several block-level requesters, e.g. the decrypted-plaintext path and a status/echo message path. It arbitrates round-robin, latches the winning block, and serializes it MSB-byte-first. It drives the UART TX byte handshake (tx_data/tx_start in, tx_busy out), so requesters never touch the UART directly. It sits between the hybrid decrypt core / status logic and the UART_TX instance in the Basys3 top.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
BLOCK_BYTES, 16, maximum bytes per block; block data width is 8*BLOCK_BYTES.
START_TIMEOUT, 1024, max cycles to wait for tx_busy to rise after a tx_start pulse.

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request; held until acknowledged
req_block  in  NUM_REQ*8*BLOCK_BYTES  requester i block at [i*8*BLOCK_BYTES +: 8*BLOCK_BYTES]; first byte sent = that slice's MSB byte
req_len  in  NUM_REQ*LW  LW=$clog2(BLOCK_BYTES+1); requester i byte count at [i*LW +: LW]
req_ack  out  NUM_REQ  one-cycle pulse: block i latched
req_done  out  NUM_REQ  one-cycle pulse: block i fully transmitted (or zero-length)
req_err  out  NUM_REQ  one-cycle pulse: block i aborted on start timeout
sched_busy  out  1  high whenever state != IDLE
tx_data  out  8  byte to UART_TX
tx_start  out  1  one-cycle start pulse to UART_TX
tx_busy  in  1  UART_TX busy

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE; tx_data=0, tx_start=0, req_ack/req_done/req_err=0, sched_busy=0; rr pointer=0; any in-flight block is dropped with no done/err pulse. All outputs are registered.
- States: IDLE, LOAD, SEND, WAIT.
- IDLE: if any req_valid, grant the first set bit scanning from rr pointer upward with wrap-around. On that edge:
  - latch block and length into buf/len;
  - byte_cnt=0;
  - req_ack[g]=1 for one cycle;
  - rr pointer = (g+1) mod NUM_REQ;
  - go to LOAD.
- Length rules at grant: len > BLOCK_BYTES is clamped to BLOCK_BYTES. len == 0 goes directly to IDLE, pulsing req_done[g] on the cycle after req_ack[g], with no tx_start.
- LOAD: tx_data = buf MSB byte, tx_start=1 for exactly one cycle, timeout counter cleared; go to SEND.
- SEND: wait for tx_busy=1, then go to WAIT. If the counter reaches START_TIMEOUT-1 with tx_busy still low: req_err[g] pulse, go to IDLE, remaining bytes discarded.
- WAIT: wait for tx_busy=0.
  - If byte_cnt == len-1: req_done[g] pulse, go to IDLE.
  - Else: buf shifted left 8, byte_cnt+1, go to LOAD.
- Latency: req_valid seen in IDLE at edge k gives req_ack high after edge k and tx_start high after edge k+1. Back-to-back bytes have exactly one LOAD cycle between tx_busy falling and the next tx_start.
- req_valid is ignored outside IDLE. A requester that keeps req_valid high after its ack is treated as a new request at the next IDLE. Rotation guarantees no starvation.
- req_block/req_len are sampled only on the grant edge; later changes do not affect the block in flight.
- A new grant may occur on the cycle immediately after the done/err cycle, since IDLE evaluates requests on its first cycle.
- At most one of req_ack/req_done/req_err is high per cycle, for at most one requester.

Test Plan:
- Req0, len=16, block=0x000102…0F, UART model (busy 10 cycles) -> tx bytes 00,01,…,0F in order; req_ack[0] once; req_done[0] once, after the 16th busy falls.
- Req1, len=3, block MSBs "O","K","\n" -> tx bytes 0x4F,0x4B,0x0A only; req_done[1] after the 3rd byte.
- Req0 and req1 both valid from reset, held high -> grant order 0,1,0,1; each block transmitted intact, never interleaved.
- Req1 len=0 -> req_ack[1] then req_done[1] on the next cycle; no tx_start. Req0 len=20 -> exactly 16 bytes sent.
- UART model never asserts busy, START_TIMEOUT=16 -> one tx_start; req_err[0] 16 cycles later; IDLE; the next request is served normally.
- rst asserted for 1 cycle during byte 5 of a 16-byte block -> next cycle all outputs 0, state IDLE, no done/err; a re-request of req1 is granted first (rr=0 scan picks 0 only if valid).
